// File: rtl/hazard_pkg.sv
// Shared definitions for the data-hazard scoreboard.
// - FSEL_RF: forwarding select meaning "read the register file".
// - Entry layout, LSB first: load flag, destination register, valid flag.
// - STALL_CNT_W: width of the saturating stall counter.
package hazard_pkg;

  localparam int unsigned FSEL_RF      = 0;
  localparam int unsigned STALL_CNT_W  = 16;

  localparam int unsigned ENT_LOAD_BIT = 0;
  localparam int unsigned ENT_RD_LSB   = 1;

  // Total bits per tracked entry for a given register address width.
  function automatic int unsigned ent_w(input int unsigned addr_w);
    return addr_w + 2;
  endfunction

  // Position of the valid flag inside an entry.
  function automatic int unsigned ent_valid_bit(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source operand against every tracked in-flight writer.
// Ports:
//   entries  : flattened entry array, position 0 (EX) in the low bits
//   src_addr : source register address of this operand
//   src_used : operand is really read by the ID instruction
//   hit      : some entry matches
//   fsel     : youngest matching position + 1, or FSEL_RF when nothing matches
//   load_hit : a matching load sits at a position whose data is not ready yet
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned PC_REG     = 15,
  parameter int unsigned FSEL_W     = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH*ent_w(REG_ADDR_W)-1:0] entries,
  input  logic [REG_ADDR_W-1:0]              src_addr,
  input  logic                               src_used,
  output logic                               hit,
  output logic [FSEL_W-1:0]                  fsel,
  output logic                               load_hit
);

  localparam int unsigned EntW     = ent_w(REG_ADDR_W);
  localparam int unsigned ValidBit = ent_valid_bit(REG_ADDR_W);

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] is_load;

  for (genvar p = 0; p < DEPTH; p++) begin : g_pos
    assign match[p] = src_used
                    & entries[p*EntW + ValidBit]
                    & (entries[p*EntW + ENT_RD_LSB +: REG_ADDR_W] == src_addr)
                    & (src_addr != REG_ADDR_W'(PC_REG));
    assign is_load[p] = entries[p*EntW + ENT_LOAD_BIT];
  end

  always_comb begin
    hit      = |match;
    fsel     = FSEL_W'(FSEL_RF);
    load_hit = 1'b0;
    // Walk oldest to youngest so the youngest writer overrides.
    for (int p = int'(DEPTH) - 1; p >= 0; p--) begin
      if (match[p]) begin
        fsel = FSEL_W'(p + 1);
        if (is_load[p] && (p < int'(LOAD_LAT))) begin
          load_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard for the ID stage: tracks in-flight register writers
// in a shift register mirroring EX..WB, issues per-operand forwarding selects
// and a load-use stall.
// Ports:
//   CLK, CLR      : clock (rising edge), asynchronous active-low reset
//   id_valid      : ID holds a real instruction
//   id_rd         : destination register of the ID instruction
//   id_rf_en      : ID instruction writes the register file
//   id_load       : ID instruction is a load
//   id_src_addr   : packed source addresses, operand k at [k*REG_ADDR_W +: REG_ADDR_W]
//   id_src_used   : per-operand "actually read" flags
//   flush         : ID instruction is squashed
//   fwd_sel       : per-operand select, 0 = register file, p+1 = position p
//   stall         : hold PC and IF/ID
//   nop_sel       : insert NOP into ID/EX
//   stall_count   : saturating count of stall cycles
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned PC_REG     = 15,
  parameter int unsigned FSEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                          CLK,
  input  logic                          CLR,
  input  logic                          id_valid,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_rf_en,
  input  logic                          id_load,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          flush,
  output logic [NUM_SRC*FSEL_W-1:0]     fwd_sel,
  output logic                          stall,
  output logic                          nop_sel,
  output logic [STALL_CNT_W-1:0]        stall_count
);

  localparam int unsigned EntW     = ent_w(REG_ADDR_W);
  localparam int unsigned ValidBit = ent_valid_bit(REG_ADDR_W);

  logic [DEPTH*EntW-1:0]  ent_q, ent_d;
  logic [EntW-1:0]        ent_new;
  logic [NUM_SRC-1:0]     op_hit, op_load_hit;
  logic                   hazard;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_op
    hazard_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .DEPTH      (DEPTH),
      .LOAD_LAT   (LOAD_LAT),
      .PC_REG     (PC_REG),
      .FSEL_W     (FSEL_W)
    ) u_match (
      .entries  (ent_q),
      .src_addr (id_src_addr[k*REG_ADDR_W +: REG_ADDR_W]),
      .src_used (id_src_used[k]),
      .hit      (op_hit[k]),
      .fsel     (fwd_sel[k*FSEL_W +: FSEL_W]),
      .load_hit (op_load_hit[k])
    );
  end

  always_comb begin
    hazard  = |(op_hit & op_load_hit);
    // Flush wins over a hazard: the instruction is squashed anyway.
    stall   = id_valid & hazard & ~flush;
    nop_sel = stall | flush;
  end

  always_comb begin
    ent_new                               = '0;
    ent_new[ValidBit]                     = id_valid & id_rf_en & ~stall & ~flush;
    ent_new[ENT_RD_LSB +: REG_ADDR_W]     = id_rd;
    ent_new[ENT_LOAD_BIT]                 = id_load;
  end

  always_comb begin
    ent_d            = '0;
    ent_d[EntW-1:0]  = ent_new;
    for (int p = 1; p < int'(DEPTH); p++) begin
      ent_d[p*EntW +: EntW] = ent_q[(p-1)*EntW +: EntW];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Default configuration: NUM_SRC=3, DEPTH=3, LOAD_LAT=1.
  logic        rst_n;
  logic        d_valid, d_rf_en, d_load, d_flush;
  logic [3:0]  d_rd;
  logic [11:0] d_src;
  logic [2:0]  d_used;
  logic [5:0]  d_fsel;
  logic        d_stall, d_nop;
  logic [15:0] d_cnt;

  hazard_scoreboard u_dut (
    .CLK         (clk),
    .CLR         (rst_n),
    .id_valid    (d_valid),
    .id_rd       (d_rd),
    .id_rf_en    (d_rf_en),
    .id_load     (d_load),
    .id_src_addr (d_src),
    .id_src_used (d_used),
    .flush       (d_flush),
    .fwd_sel     (d_fsel),
    .stall       (d_stall),
    .nop_sel     (d_nop),
    .stall_count (d_cnt)
  );

  // Sweep configuration: NUM_SRC=4, DEPTH=4, LOAD_LAT=2.
  logic        s_valid, s_rf_en, s_load, s_flush;
  logic [3:0]  s_rd;
  logic [15:0] s_src;
  logic [3:0]  s_used;
  logic [11:0] s_fsel;
  logic        s_stall, s_nop;
  logic [15:0] s_cnt;

  hazard_scoreboard #(
    .NUM_SRC  (4),
    .DEPTH    (4),
    .LOAD_LAT (2)
  ) u_sweep (
    .CLK         (clk),
    .CLR         (rst_n),
    .id_valid    (s_valid),
    .id_rd       (s_rd),
    .id_rf_en    (s_rf_en),
    .id_load     (s_load),
    .id_src_addr (s_src),
    .id_src_used (s_used),
    .flush       (s_flush),
    .fwd_sel     (s_fsel),
    .stall       (s_stall),
    .nop_sel     (s_nop),
    .stall_count (s_cnt)
  );

  // Saturation configuration: every load stalls 16 of every 17 cycles.
  logic        sat_rst_n;
  logic [4:0]  t_fsel;
  logic        t_stall, t_nop;
  logic [15:0] t_cnt;

  hazard_scoreboard #(
    .NUM_SRC  (1),
    .DEPTH    (16),
    .LOAD_LAT (16)
  ) u_sat (
    .CLK         (clk),
    .CLR         (sat_rst_n),
    .id_valid    (1'b1),
    .id_rd       (4'd2),
    .id_rf_en    (1'b1),
    .id_load     (1'b1),
    .id_src_addr (4'd2),
    .id_src_used (1'b1),
    .flush       (1'b0),
    .fwd_sel     (t_fsel),
    .stall       (t_stall),
    .nop_sel     (t_nop),
    .stall_count (t_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  rd;
    logic        rf_en;
    logic        load;
    logic [11:0] src;
    logic [2:0]  used;
    logic        flush;
    logic [5:0]  e_fsel;
    logic        e_stall;
    logic        e_nop;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NumVec = 19;
  vec_t vecs [NumVec];

  function automatic vec_t mk(input logic v, input logic [3:0] rd, input logic rf,
                              input logic ld, input logic [11:0] src, input logic [2:0] used,
                              input logic fl, input logic [5:0] fs, input logic st,
                              input logic np, input logic [15:0] cnt);
    return '{v, rd, rf, ld, src, used, fl, fs, st, np, cnt};
  endfunction

  initial begin
    // Sequential program; src is {C,B,A}, fsel is {C,B,A} 2 bits each.
    vecs[0]  = mk(0, 0,  0, 0, 12'h000, 3'b000, 0, 6'b000000, 0, 0, 0);  // idle
    vecs[1]  = mk(1, 1,  1, 0, 12'h000, 3'b000, 0, 6'b000000, 0, 0, 0);  // ADD R1
    vecs[2]  = mk(1, 4,  1, 0, 12'h001, 3'b001, 0, 6'b000001, 0, 0, 0);  // A=R1 @EX
    vecs[3]  = mk(1, 5,  1, 0, 12'h001, 3'b001, 0, 6'b000010, 0, 0, 0);  // A=R1 @MEM
    vecs[4]  = mk(1, 0,  0, 0, 12'h541, 3'b111, 0, 6'b011011, 0, 0, 0);  // all three
    vecs[5]  = mk(1, 2,  1, 1, 12'h000, 3'b000, 0, 6'b000000, 0, 0, 0);  // LDR R2
    vecs[6]  = mk(1, 6,  1, 0, 12'h020, 3'b010, 0, 6'b000100, 1, 1, 0);  // load-use
    vecs[7]  = mk(1, 6,  1, 0, 12'h020, 3'b010, 0, 6'b001000, 0, 0, 1);  // released
    vecs[8]  = mk(1, 3,  1, 0, 12'h000, 3'b000, 0, 6'b000000, 0, 0, 1);  // ADD R3
    vecs[9]  = mk(1, 15, 1, 0, 12'h000, 3'b000, 0, 6'b000000, 0, 0, 1);  // write PC
    vecs[10] = mk(1, 3,  1, 0, 12'h000, 3'b000, 0, 6'b000000, 0, 0, 1);  // ADD R3
    vecs[11] = mk(1, 0,  0, 0, 12'h3F3, 3'b111, 0, 6'b010001, 0, 0, 1);  // youngest, R15
    vecs[12] = mk(1, 9,  1, 1, 12'h009, 3'b001, 0, 6'b000000, 0, 0, 1);  // own rd
    vecs[13] = mk(1, 10, 1, 0, 12'h009, 3'b001, 1, 6'b000001, 0, 1, 1);  // flush+hazard
    vecs[14] = mk(1, 0,  0, 0, 12'h09A, 3'b011, 0, 6'b001000, 0, 0, 1);  // flushed rd gone
    vecs[15] = mk(1, 11, 1, 1, 12'h000, 3'b000, 0, 6'b000000, 0, 0, 1);  // LDR R11
    vecs[16] = mk(0, 0,  0, 0, 12'h00B, 3'b001, 0, 6'b000001, 0, 0, 1);  // invalid ID
    vecs[17] = mk(0, 0,  0, 0, 12'h000, 3'b000, 1, 6'b000000, 0, 1, 1);  // bare flush
    vecs[18] = mk(1, 0,  0, 0, 12'h00B, 3'b001, 0, 6'b000011, 0, 0, 1);  // R11 @WB

    rst_n     = 1'b0;
    sat_rst_n = 1'b0;
    d_valid = 0; d_rd = 0; d_rf_en = 0; d_load = 0; d_src = 0; d_used = 0; d_flush = 0;
    s_valid = 0; s_rd = 0; s_rf_en = 0; s_load = 0; s_src = 0; s_used = 0; s_flush = 0;

    #3;
    check("reset fsel", 32'(d_fsel), 32'h0);
    check("reset stall", 32'(d_stall), 32'h0);
    check("reset nop", 32'(d_nop), 32'h0);
    check("reset cnt", 32'(d_cnt), 32'h0);
    d_flush = 1'b1;
    #1;
    check("reset nop=flush", 32'(d_nop), 32'h1);
    d_flush = 1'b0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      d_valid = vecs[i].valid;
      d_rd    = vecs[i].rd;
      d_rf_en = vecs[i].rf_en;
      d_load  = vecs[i].load;
      d_src   = vecs[i].src;
      d_used  = vecs[i].used;
      d_flush = vecs[i].flush;
      #1;
      check($sformatf("v%0d fsel", i), 32'(d_fsel), 32'(vecs[i].e_fsel));
      check($sformatf("v%0d stall", i), 32'(d_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d nop", i), 32'(d_nop), 32'(vecs[i].e_nop));
      check($sformatf("v%0d cnt", i), 32'(d_cnt), 32'(vecs[i].e_cnt));
    end

    @(negedge clk);
    d_valid = 0; d_rf_en = 0; d_load = 0; d_used = 0; d_flush = 0;

    // Sweep: LDR R2 then a consumer on operand D, two stall cycles.
    @(negedge clk);
    s_valid = 1; s_rd = 2; s_rf_en = 1; s_load = 1; s_src = 0; s_used = 0;
    #1;
    check("sw ldr stall", 32'(s_stall), 32'h0);
    @(negedge clk);
    s_rd = 6; s_load = 0; s_src = 16'h2000; s_used = 4'b1000;
    #1;
    check("sw stall1", 32'(s_stall), 32'h1);
    check("sw nop1", 32'(s_nop), 32'h1);
    check("sw fsel1", 32'(s_fsel), 32'h200);
    @(negedge clk);
    #1;
    check("sw stall2", 32'(s_stall), 32'h1);
    check("sw fsel2", 32'(s_fsel), 32'h400);
    @(negedge clk);
    #1;
    check("sw stall3", 32'(s_stall), 32'h0);
    check("sw fsel3", 32'(s_fsel), 32'h600);
    check("sw cnt", 32'(s_cnt), 32'h2);
    @(negedge clk);
    s_valid = 0; s_rf_en = 0; s_used = 0;

    // Reset dropped in the middle of a load-use stall.
    @(negedge clk);
    d_valid = 1; d_rd = 2; d_rf_en = 1; d_load = 1; d_src = 0; d_used = 0;
    @(negedge clk);
    d_rd = 7; d_load = 0; d_src = 12'h022; d_used = 3'b011;
    #1;
    check("mid stall", 32'(d_stall), 32'h1);
    check("mid fsel", 32'(d_fsel), 32'h05);
    check("mid cnt", 32'(d_cnt), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst stall", 32'(d_stall), 32'h0);
    check("rst fsel", 32'(d_fsel), 32'h0);
    check("rst nop", 32'(d_nop), 32'h0);
    check("rst cnt", 32'(d_cnt), 32'h0);
    check("rst sw cnt", 32'(s_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post rst stall", 32'(d_stall), 32'h0);
    @(negedge clk);
    d_valid = 0; d_rf_en = 0; d_used = 0;

    // Saturation of the stall counter.
    @(negedge clk);
    sat_rst_n = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    check("sat early cnt", 32'(t_cnt), 32'd16);
    repeat (69983) @(posedge clk);
    #1;
    check("sat cnt", 32'(t_cnt), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
